// File: rtl/img_frame_loader.sv
// img_frame_loader: collects an MSB-first byte stream into one wide camera
// frame and holds the last good frame steady on a parallel bus. Frames with
// the wrong number of beats are discarded and flagged on frame_err.
module img_frame_loader #(
  parameter int DATA_W  = 8,
  parameter int FRAME_W = 3072
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  input  logic [DATA_W-1:0]  s_data,
  input  logic               s_last,
  output logic               s_ready,
  output logic [FRAME_W-1:0] frame_out,
  output logic               frame_valid,
  output logic               frame_err,
  output logic [7:0]         frame_cnt
);

  localparam int BEATS = FRAME_W / DATA_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    DRAIN  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_nxt;
  logic [FRAME_W-1:0] assem;
  logic [FRAME_W-1:0] assem_shift;
  logic               accept;
  logic               do_shift;
  logic               do_commit;
  logic               do_err;

  assign accept      = s_valid & s_ready;
  assign assem_shift = {assem[FRAME_W-DATA_W-1:0], s_data};

  // State and beat counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FILL;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Next-state logic: decides per accepted beat whether to keep filling,
  // commit a complete frame, or throw away a short/long one.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    do_shift  = 1'b0;
    do_commit = 1'b0;
    do_err    = 1'b0;
    case (state)
      FILL: begin
        if (accept) begin
          do_shift = 1'b1;
          if (count == LAST_CNT) begin
            count_nxt = '0;
            if (s_last) begin
              do_commit = 1'b1;
              state_nxt = COMMIT;
            end else begin
              do_err    = 1'b1;
              state_nxt = DRAIN;
            end
          end else if (s_last) begin
            do_err    = 1'b1;
            count_nxt = '0;
          end else begin
            count_nxt = count + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (accept && s_last) begin
          state_nxt = FILL;
          count_nxt = '0;
        end
      end
      COMMIT: begin
        state_nxt = FILL;
      end
      default: begin
        state_nxt = FILL;
        count_nxt = '0;
      end
    endcase
  end

  // Datapath and registered outputs: shift in beats, publish on commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      assem       <= '0;
      frame_out   <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_cnt   <= '0;
      s_ready     <= 1'b0;
    end else begin
      if (do_shift) begin
        assem <= assem_shift;
      end
      if (do_commit) begin
        frame_out <= assem_shift;
        frame_cnt <= frame_cnt + 8'd1;
      end
      frame_valid <= do_commit;
      frame_err   <= do_err;
      s_ready     <= (state_nxt != COMMIT);
    end
  end

endmodule

// File: tb/tb_img_frame_loader.sv
// Directed testbench for img_frame_loader: a full-size instance for the
// frame assembly scenarios and a 4-beat instance for the counter wrap.
module tb_img_frame_loader;

  localparam int DW  = 8;
  localparam int FW  = 3072;
  localparam int NB  = FW / DW;
  localparam int SFW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic [FW-1:0] frame_out;
  logic          frame_valid;
  logic          frame_err;
  logic [7:0]    frame_cnt;

  logic           s_valid2 = 1'b0;
  logic [DW-1:0]  s_data2 = '0;
  logic           s_last2 = 1'b0;
  logic           s_ready2;
  logic [SFW-1:0] frame_out2;
  logic           frame_valid2;
  logic           frame_err2;
  logic [7:0]     frame_cnt2;

  int checks = 0;
  int fails = 0;
  int fv_seen = 0;
  int fe_seen = 0;
  int fv2_seen = 0;
  logic mon_en = 1'b0;
  logic [FW-1:0] fo_prev = '0;
  logic [FW-1:0] exp_nom;

  always #5 clk = ~clk;

  img_frame_loader #(.DATA_W(DW), .FRAME_W(FW)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data),
    .s_last(s_last), .s_ready(s_ready), .frame_out(frame_out),
    .frame_valid(frame_valid), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  img_frame_loader #(.DATA_W(DW), .FRAME_W(SFW)) dut_small (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid2), .s_data(s_data2),
    .s_last(s_last2), .s_ready(s_ready2), .frame_out(frame_out2),
    .frame_valid(frame_valid2), .frame_err(frame_err2), .frame_cnt(frame_cnt2)
  );

  // Pulse counting plus invariants: no simultaneous valid/err, and frame_out
  // only moves on a commit (or to zero on reset).
  always @(negedge clk) begin
    if (mon_en) begin
      checks += 2;
      if (frame_valid === 1'b1 && frame_err === 1'b1) begin
        fails++;
        $display("[TB] FAIL valid_err_overlap: frame_valid=%b frame_err=%b required not both 1", frame_valid, frame_err);
      end
      if (frame_out !== fo_prev && frame_valid !== 1'b1 && frame_out !== '0) begin
        fails++;
        $display("[TB] FAIL frame_out_stable: frame_out changed without frame_valid at %0t", $time);
      end
      fo_prev = frame_out;
      if (frame_valid === 1'b1) fv_seen++;
      if (frame_err === 1'b1) fe_seen++;
      if (frame_valid2 === 1'b1) fv2_seen++;
    end
  end

  // Watchdog so a stuck design still ends the run.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic push(input logic [7:0] d, input logic l);
    int guard;
    guard = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    while (s_ready !== 1'b1 && guard < 8) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (guard >= 8) begin
      fails++;
      $display("[TB] FAIL push_ready: s_ready=%b required 1 within 8 cycles", s_ready);
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic push2(input logic [7:0] d, input logic l);
    int guard;
    guard = 0;
    s_valid2 = 1'b1; s_data2 = d; s_last2 = l;
    while (s_ready2 !== 1'b1 && guard < 8) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (guard >= 8) begin
      fails++;
      $display("[TB] FAIL push2_ready: s_ready=%b required 1 within 8 cycles", s_ready2);
    end
    @(posedge clk); #1;
    s_valid2 = 1'b0; s_last2 = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b1; s_data = 8'hFF; s_last = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    checks++;
    if (s_ready !== 1'b0 || frame_valid !== 1'b0 || frame_err !== 1'b0 || frame_cnt !== 8'd0 || frame_out !== '0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: ready=%b fv=%b fe=%b cnt=%0d out_nonzero=%b required all 0", s_ready, frame_valid, frame_err, frame_cnt, |frame_out);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_ready_hold: s_ready=%b required 0 before first edge", s_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (s_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_ready_rise: s_ready=%b required 1", s_ready);
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic test_nominal();
    int fv0;
    fv0 = fv_seen;
    exp_nom = '0;
    for (int i = 0; i < NB; i++) exp_nom = {exp_nom[FW-DW-1:0], 8'(i)};
    for (int i = 0; i < NB; i++) push(8'(i), i == NB - 1);
    checks++;
    if (frame_valid !== 1'b1 || s_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL nominal_commit: fv=%b ready=%b required fv=1 ready=0", frame_valid, s_ready);
    end
    checks++;
    if (frame_out[FW-1:FW-8] !== 8'h00 || frame_out[7:0] !== 8'h7F) begin
      fails++;
      $display("[TB] FAIL nominal_ends: msb=%h lsb=%h required 00/7f", frame_out[FW-1:FW-8], frame_out[7:0]);
    end
    checks++;
    if (frame_out !== exp_nom) begin
      fails++;
      $display("[TB] FAIL nominal_frame: frame_out differs from expected ramp");
    end
    checks++;
    if (frame_cnt !== 8'd1) begin
      fails++;
      $display("[TB] FAIL nominal_cnt: frame_cnt=%0d required 1", frame_cnt);
    end
    @(posedge clk); #1;
    checks++;
    if (frame_valid !== 1'b0 || s_ready !== 1'b1 || fv_seen != fv0 + 1) begin
      fails++;
      $display("[TB] FAIL nominal_pulse: fv=%b ready=%b pulses=%0d required 0/1/%0d", frame_valid, s_ready, fv_seen - fv0, 1);
    end
  endtask

  task automatic test_bubbles();
    int fv0;
    int fe0;
    fv0 = fv_seen; fe0 = fe_seen;
    for (int i = 0; i < NB; i++) begin
      if ($urandom_range(0, 2) == 0 || i % 50 == 25) begin
        repeat ($urandom_range(1, 3)) begin
          s_valid = 1'b0; s_data = 8'($urandom); s_last = 1'b1;
          @(posedge clk); #1;
        end
        s_last = 1'b0;
      end
      push(8'(i), i == NB - 1);
    end
    checks++;
    if (frame_valid !== 1'b1 || frame_out !== exp_nom || frame_cnt !== 8'd2) begin
      fails++;
      $display("[TB] FAIL bubbles_commit: fv=%b match=%b cnt=%0d required 1/1/2", frame_valid, frame_out === exp_nom, frame_cnt);
    end
    @(posedge clk); #1;
    checks++;
    if (frame_valid !== 1'b0 || fv_seen != fv0 + 1 || fe_seen != fe0) begin
      fails++;
      $display("[TB] FAIL bubbles_pulse: fv=%b pulses=%0d errs=%0d required 0/1/0", frame_valid, fv_seen - fv0, fe_seen - fe0);
    end
  endtask

  task automatic test_short();
    int fe0;
    do_reset(2);
    fe0 = fe_seen;
    for (int i = 0; i < 100; i++) push(8'h11, i == 99);
    checks++;
    if (frame_err !== 1'b1 || frame_valid !== 1'b0 || frame_out !== '0 || frame_cnt !== 8'd0 || s_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL short_err: fe=%b fv=%b out_nonzero=%b cnt=%0d ready=%b required 1/0/0/0/1", frame_err, frame_valid, |frame_out, frame_cnt, s_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (frame_err !== 1'b0 || fe_seen != fe0 + 1) begin
      fails++;
      $display("[TB] FAIL short_pulse: fe=%b errs=%0d required 0/1", frame_err, fe_seen - fe0);
    end
    for (int i = 0; i < NB; i++) begin
      push(8'hA5, i == NB - 1);
      if (i == NB - 2) begin
        checks++;
        if (frame_out !== '0) begin
          fails++;
          $display("[TB] FAIL short_hold: frame_out changed before commit");
        end
      end
    end
    checks++;
    if (frame_valid !== 1'b1 || frame_out !== {NB{8'hA5}} || frame_cnt !== 8'd1 || fe_seen != fe0 + 1) begin
      fails++;
      $display("[TB] FAIL short_recover: fv=%b match=%b cnt=%0d errs=%0d required 1/1/1/1", frame_valid, frame_out === {NB{8'hA5}}, frame_cnt, fe_seen - fe0);
    end
  endtask

  task automatic test_long();
    int fe0;
    logic [FW-1:0] exp_f;
    fe0 = fe_seen;
    for (int i = 0; i < 390; i++) begin
      push(8'(i) ^ 8'h3C, i == 389);
      if (i == NB - 1) begin
        checks++;
        if (frame_err !== 1'b1 || frame_valid !== 1'b0 || frame_cnt !== 8'd1 || frame_out !== {NB{8'hA5}}) begin
          fails++;
          $display("[TB] FAIL long_err: fe=%b fv=%b cnt=%0d kept=%b required 1/0/1/1", frame_err, frame_valid, frame_cnt, frame_out === {NB{8'hA5}});
        end
      end
      if (i == NB) begin
        checks++;
        if (frame_err !== 1'b0 || s_ready !== 1'b1) begin
          fails++;
          $display("[TB] FAIL long_drain: fe=%b ready=%b required 0/1", frame_err, s_ready);
        end
      end
    end
    checks++;
    if (frame_err !== 1'b0 || frame_valid !== 1'b0 || fe_seen != fe0 + 1) begin
      fails++;
      $display("[TB] FAIL long_end: fe=%b fv=%b errs=%0d required 0/0/1", frame_err, frame_valid, fe_seen - fe0);
    end
    exp_f = '0;
    for (int i = 0; i < NB; i++) exp_f = {exp_f[FW-DW-1:0], 8'(i * 7 + 1)};
    for (int i = 0; i < NB; i++) push(8'(i * 7 + 1), i == NB - 1);
    checks++;
    if (frame_valid !== 1'b1 || frame_out !== exp_f || frame_cnt !== 8'd2) begin
      fails++;
      $display("[TB] FAIL long_recover: fv=%b match=%b cnt=%0d required 1/1/2", frame_valid, frame_out === exp_f, frame_cnt);
    end
  endtask

  task automatic test_midframe_reset();
    int fv0;
    int fe0;
    for (int i = 0; i < 200; i++) push(8'(i), 1'b0);
    fv0 = fv_seen; fe0 = fe_seen;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (frame_out !== '0 || frame_cnt !== 8'd0 || s_ready !== 1'b0 || frame_valid !== 1'b0 || frame_err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midreset_outputs: out_nonzero=%b cnt=%0d ready=%b fv=%b fe=%b required all 0", |frame_out, frame_cnt, s_ready, frame_valid, frame_err);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (fv_seen != fv0 || fe_seen != fe0 || frame_out !== '0) begin
      fails++;
      $display("[TB] FAIL midreset_nopulse: pulses=%0d errs=%0d required 0/0", fv_seen - fv0, fe_seen - fe0);
    end
    for (int i = 0; i < NB; i++) push(8'(i), i == NB - 1);
    checks++;
    if (frame_valid !== 1'b1 || frame_out !== exp_nom || frame_cnt !== 8'd1) begin
      fails++;
      $display("[TB] FAIL midreset_recover: fv=%b match=%b cnt=%0d required 1/1/1", frame_valid, frame_out === exp_nom, frame_cnt);
    end
  endtask

  task automatic test_counter_wrap();
    int fv0;
    fv0 = fv2_seen;
    for (int f = 0; f < 256; f++) begin
      for (int b = 0; b < 4; b++) push2(8'(f + b), b == 3);
      checks++;
      if (frame_cnt2 !== 8'(f + 1) || frame_valid2 !== 1'b1) begin
        fails++;
        $display("[TB] FAIL wrap_cnt: frame %0d cnt=%0d fv=%b required %0d/1", f, frame_cnt2, frame_valid2, (f + 1) % 256);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (frame_cnt2 !== 8'd0 || fv2_seen != fv0 + 256 || frame_out2 !== 32'hFF000102 || frame_err2 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL wrap_final: cnt=%0d pulses=%0d out=%h fe=%b required 0/256/ff000102/0", frame_cnt2, fv2_seen - fv0, frame_out2, frame_err2);
    end
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_nominal();
    test_bubbles();
    test_short();
    test_long();
    test_midframe_reset();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/img_frame_loader.md
# img_frame_loader

Upstream feeder for one traffic-signal approach. It assembles a 3072-bit camera frame from an 8-bit valid/ready byte stream and presents it on a stable parallel bus that drives the `imgData` input of a `TrafficSignal` instance. It replaces file-based frame injection with a synthesizable path. The design instantiates five copies, one per approach: Mid, L, R, T and D.

## Interface

Parameters:
- `DATA_W`, default 8: stream beat width in bits.
- `FRAME_W`, default 3072: frame width in bits. Must be a multiple of `DATA_W`.
- `BEATS`: derived, equal to `FRAME_W/DATA_W` (384 with the defaults).

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `s_valid`  in  1: a stream beat is offered.
- `s_data`  in  `DATA_W`: beat payload. The first beat of a frame maps to the frame MSBs.
- `s_last`  in  1: marks the final beat of a frame.
- `s_ready`  out  1: the loader accepts a beat this cycle.
- `frame_out`  out  `FRAME_W`: last committed frame, held stable between commits. Connects to `imgData` of `TrafficSignal`.
- `frame_valid`  out  1: one-cycle pulse when `frame_out` has just been updated.
- `frame_err`  out  1: one-cycle pulse when a malformed frame is discarded.
- `frame_cnt`  out  8: count of committed frames, wraps 255→0.

## Operation

- A beat is accepted when `s_valid` and `s_ready` are both high on a rising edge.
- The assembly register shifts left by `DATA_W` on each accepted beat and takes `s_data` into the LSBs. After `BEATS` beats, the first beat occupies `[FRAME_W-1:FRAME_W-DATA_W]`, matching MSB-first `%b` file order.
- Beat counter: 9 bits (`ceil(log2(BEATS))`), range 0..`BEATS-1`.
- FSM states:
  - FILL: `s_ready`=1.
    - Accepted beat with count < `BEATS-1` and `s_last`=0: increment the count and stay in FILL.
    - Accepted beat with count = `BEATS-1` and `s_last`=1: load `frame_out` with the shifted assembly value (including this beat), clear the count, increment `frame_cnt`, and go to COMMIT.
    - Accepted beat with `s_last`=1 and count < `BEATS-1` (short frame): discard the frame, clear the count, pulse `frame_err`, and stay in FILL.
    - Accepted beat with count = `BEATS-1` and `s_last`=0 (long frame): discard, clear the count, pulse `frame_err`, and go to DRAIN.
  - DRAIN: `s_ready`=1. Accepted beats are dropped. An accepted beat with `s_last`=1 returns the FSM to FILL with count 0. No second error pulse is generated.
  - COMMIT: `s_ready`=0 for exactly one cycle, during which `frame_valid`=1. The FSM then returns to FILL.
- `frame_out` changes only on a commit edge. A discarded frame never alters `frame_out` or `frame_cnt`.
- The assembly register is not cleared on discard. Stale bits are fully shifted out by the next complete frame.
- `s_data` and `s_last` are ignored when `s_valid`=0, including bubbles mid-frame; the count holds.

## Timing

- Reset (`rst_n`=0 at an edge) produces:
  - `s_ready`=0, `frame_out`=0, `frame_valid`=0, `frame_err`=0, `frame_cnt`=0;
  - count=0, state=FILL, assembly register=0.
- `s_ready` rises on the first edge with `rst_n`=1, so the first beat can be accepted one cycle after reset release.
- Latency: if the final beat is accepted at edge N, then `frame_out` and `frame_cnt` are updated and `frame_valid`=1 from edge N to edge N+1. `s_ready`=0 over the same interval, and `s_ready`=1 again from edge N+1.
- Minimum frame period is `BEATS`+1 cycles (385), due to the one-cycle COMMIT bubble.
- `frame_err` is high for the cycle following the edge on which the offending beat was accepted.
- Reset mid-frame or in DRAIN/COMMIT: partial data is lost, all outputs take their reset values, and there is no `frame_valid` or `frame_err` pulse.
- `frame_valid` and `frame_err` are never high in the same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- **Reset:** hold `rst_n`=0 for 3 cycles with `s_valid`=1. Required: all outputs 0, and `s_ready` rises exactly 1 cycle after release.
- **Nominal frame:** 384 back-to-back beats with `s_data`=beat index[7:0] and `s_last` on beat 383. Required:
  - `frame_out[3071:3064]`=8'h00 and `frame_out[7:0]`=8'h7F (383 mod 256 = 127);
  - `frame_valid` pulses once, 1 cycle after the last beat;
  - `frame_cnt`=1;
  - `s_ready` is low for that single cycle.
- **Bubbles:** the same frame with `s_valid` toggled at random. Required: identical `frame_out` and commit after 384 accepted beats; `frame_valid` is still a 1-cycle pulse.
- **Short frame:** `s_last` on beat 99, followed by a full valid frame of all 8'hA5. Required: `frame_err` pulses once after beat 99, `frame_out` is unchanged (0) until the second frame commits, then `frame_out` is all 0xA5 and `frame_cnt`=1.
- **Long frame:** 390 beats with `s_last` only on beat 389, then a valid frame. Required: `frame_err` pulses once after beat 383, beats 384..389 are dropped in DRAIN, and the next frame commits correctly.
- **Reset mid-frame, then counter wrap:**
  - Assert `rst_n`=0 at beat 200. Required: no pulse, `frame_out`=0.
  - Then stream 256 good frames. Required: `frame_cnt` wraps to 0 and `frame_valid` pulses 256 times.
